// File: rtl/node_table_pkg.sv
// rtl/node_table_pkg.sv - shared defaults and scan state encoding for the node table bank
package node_table_pkg;

    localparam int WORD_WIDTH_DEF = 16;
    localparam int MEM_DEPTH_DEF  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/node_table_scan.sv
// rtl/node_table_scan.sv - max-search engine walking the node table one entry per cycle
module node_table_scan
    import node_table_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  scan_start,
    input  logic                  clr_all,
    output logic [ADDR_WIDTH-1:0] ptr,
    input  logic [WORD_WIDTH-1:0] entry_word,
    input  logic                  entry_valid,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic                  scan_found,
    output logic [ADDR_WIDTH-1:0] scan_index,
    output logic [WORD_WIDTH-1:0] scan_max
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    scan_state_t state, next_state;

    logic                  work_found;
    logic [ADDR_WIDTH-1:0] work_index;
    logic [WORD_WIDTH-1:0] work_best;
    logic                  take;

    // Strict greater-than keeps the lower index on ties.
    assign take      = entry_valid && (!work_found || (entry_word > work_best));
    assign scan_busy = (state == SCAN);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (scan_start) next_state = SCAN;
            SCAN: begin
                if (clr_all)          next_state = IDLE;
                else if (ptr == LAST) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            ptr        <= '0;
            work_found <= 1'b0;
            work_index <= '0;
            work_best  <= '0;
            scan_done  <= 1'b0;
            scan_found <= 1'b0;
            scan_index <= '0;
            scan_max   <= '0;
        end else begin
            state     <= next_state;
            scan_done <= (state == DONE);
            if (state == IDLE && scan_start) begin
                ptr        <= '0;
                work_found <= 1'b0;
                work_index <= '0;
                work_best  <= '0;
            end else if (state == SCAN && !clr_all) begin
                if (take) begin
                    work_found <= 1'b1;
                    work_index <= ptr;
                    work_best  <= entry_word;
                end
                if (ptr != LAST) ptr <= ptr + 1'b1;
            end
            // Results publish together with scan_done; an aborted scan never reaches DONE.
            if (state == DONE) begin
                scan_found <= work_found;
                scan_index <= work_index;
                scan_max   <= work_best;
            end
        end
    end

endmodule

// File: rtl/node_table_bank.sv
// rtl/node_table_bank.sv - per-neighbour word table with valid bits, live count and max scan
module node_table_bank
    import node_table_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  wr_en,
    input  logic                  inv_en,
    input  logic                  clr_all,
    input  logic [ADDR_WIDTH-1:0] wr_index,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_index,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  scan_start,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic                  scan_found,
    output logic [ADDR_WIDTH-1:0] scan_index,
    output logic [WORD_WIDTH-1:0] scan_max
);

    logic [WORD_WIDTH-1:0] mem [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]  valid;
    logic [ADDR_WIDTH-1:0] scan_ptr;
    logic                  wr_hit_valid;

    assign wr_hit_valid = valid[wr_index];

    // Storage has no reset; only the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (wr_en && !clr_all) mem[wr_index] <= wr_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid    <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= mem[rd_index];
            rd_valid <= valid[rd_index];
            if (clr_all) begin
                valid <= '0;
                count <= '0;
            end else if (wr_en) begin
                valid[wr_index] <= 1'b1;
                if (!wr_hit_valid) count <= count + (ADDR_WIDTH + 1)'(1);
            end else if (inv_en) begin
                valid[wr_index] <= 1'b0;
                if (wr_hit_valid) count <= count - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    node_table_scan #(
        .WORD_WIDTH (WORD_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_scan (
        .clk         (clk),
        .nrst        (nrst),
        .scan_start  (scan_start),
        .clr_all     (clr_all),
        .ptr         (scan_ptr),
        .entry_word  (mem[scan_ptr]),
        .entry_valid (valid[scan_ptr]),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .scan_found  (scan_found),
        .scan_index  (scan_index),
        .scan_max    (scan_max)
    );

endmodule
